// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and LSU state type
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - request/response handshake bundle for lsu_mem
interface lsu_mem_if #(
    parameter int XLEN = riscv_pkg::XLEN
) ();
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [2:0]      req_funct3_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane select, sign extension, byte enables; LSU_MISALIGN_TRAP_EN faults misaligned accesses
module lsu_align #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] mem_word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word,
    output logic [3:0]      byte_en,
    output logic            err
);
    import riscv_pkg::*;

    logic [1:0]  off;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Decode legality, effective lane offset, extracted load value and store lanes
    always_comb begin
        err = we ? (funct3 > F3_SW)
                 : !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
`ifdef LSU_MISALIGN_TRAP_EN
        if (funct3[1:0] == 2'b01 && addr_lo[0])     err = 1'b1;
        if (funct3[1:0] == 2'b10 && addr_lo != 2'b00) err = 1'b1;
`endif
        // Without the trap, misaligned halves/words simply drop the low bits.
        case (funct3[1:0])
            2'b01:   off = {addr_lo[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = addr_lo;
        endcase

        case (off)
            2'd0:    lane_b = mem_word[7:0];
            2'd1:    lane_b = mem_word[15:8];
            2'd2:    lane_b = mem_word[23:16];
            default: lane_b = mem_word[31:24];
        endcase
        lane_h = off[1] ? mem_word[31:16] : mem_word[15:0];

        load_data = '0;
        if (!we && !err) begin
            case (funct3)
                F3_LB:   load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
                F3_LH:   load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
                F3_LW:   load_data = mem_word;
                F3_LBU:  load_data = {{(XLEN-8){1'b0}}, lane_b};
                F3_LHU:  load_data = {{(XLEN-16){1'b0}}, lane_h};
                default: load_data = '0;
            endcase
        end

        byte_en    = 4'b0000;
        store_word = wdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << off;
                store_word = {(XLEN/8){wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = 4'b0011 << off;
                store_word = {(XLEN/16){wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        if (!we || err) byte_en = 4'b0000;
    end
endmodule

// File: rtl/lsu_mem.sv
// rtl/lsu_mem.sv - load/store unit over a word memory; LSU_MISALIGN_TRAP_EN enables misalign faults
module lsu_mem #(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int MEM_SIZE = 2048,
    parameter int LATENCY  = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    lsu_mem_if.slave                    bus,
    output logic                        busy_o,
    input  logic [$clog2(MEM_SIZE)-1:0] dbg_addr_i,
    output logic [XLEN-1:0]             dbg_data_o
);
    import riscv_pkg::*;

    localparam int AW = $clog2(MEM_SIZE);

    logic [XLEN-1:0] mem [MEM_SIZE];

    lsu_state_e      state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_addr, r_wdata;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic            accept, do_access;
    logic            a_we;
    logic [2:0]      a_f3;
    logic [XLEN-1:0] a_addr, a_wdata;
    logic [AW-1:0]   a_idx;
    logic [XLEN-1:0] ld_data, st_word;
    logic [3:0]      be;
    logic            acc_err;
    logic            unused_addr_bits;

    assign bus.req_ready_o = (state == IDLE) && rstn_i;
    assign bus.rsp_valid_o = (state == RESP);
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign busy_o          = (state != IDLE);
    assign dbg_data_o      = mem[dbg_addr_i];
    assign accept          = bus.req_valid_i && bus.req_ready_o;

    // With zero latency the access happens on the accept edge straight from the request inputs.
    assign a_we    = (state == IDLE) ? bus.req_we_i     : r_we;
    assign a_f3    = (state == IDLE) ? bus.req_funct3_i : r_f3;
    assign a_addr  = (state == IDLE) ? bus.req_addr_i   : r_addr;
    assign a_wdata = (state == IDLE) ? bus.req_wdata_i  : r_wdata;
    assign a_idx   = a_addr[AW+1:2];
    assign unused_addr_bits = ^a_addr[XLEN-1:AW+2];

    lsu_align #(.XLEN(XLEN)) u_align (
        .we         (a_we),
        .funct3     (a_f3),
        .addr_lo    (a_addr[1:0]),
        .mem_word   (mem[a_idx]),
        .wdata      (a_wdata),
        .load_data  (ld_data),
        .store_word (st_word),
        .byte_en    (be),
        .err        (acc_err)
    );

    // Next-state, wait countdown and access strobe
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (LATENCY == 0) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt   = 3'(LATENCY);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: if (bus.rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, captured request and held response
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            r_we        <= 1'b0;
            r_f3        <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                r_we    <= bus.req_we_i;
                r_f3    <= bus.req_funct3_i;
                r_addr  <= bus.req_addr_i;
                r_wdata <= bus.req_wdata_i;
            end
            if (do_access) begin
                rsp_rdata_q <= ld_data;
                rsp_err_q   <= acc_err;
            end
        end
    end

    // Byte-lane memory write; contents survive reset, and reset cancels a pending store
    always_ff @(posedge clk_i) begin
        if (rstn_i && do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[a_idx][8*i +: 8] <= st_word[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem.sv
// tb/tb_lsu_mem.sv - directed bench for lsu_mem
module tb_lsu_mem;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        busy;
    logic [10:0] dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int failures = 0;

    lsu_mem_if #(.XLEN(32)) bus ();

    lsu_mem dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .bus        (bus),
        .busy_o     (busy),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for its response; lat counts cycles from accept to rsp_valid.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.rsp_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'd0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.rsp_ready_i  = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
        check_eq("rst_req_ready", bus.req_ready_o, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdata", bus.rsp_rdata_o, 0);
        check_eq("rst_err", bus.rsp_err_o, 0);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("idle_req_ready", bus.req_ready_o, 1);

        // SW then LW
        xact(1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check_eq("sw_latency", lat, 2);
        check_eq("sw_err", er, 0);
        check_eq("sw_rdata", rd, 0);
        dbg_addr = 11'd4;
        #1 check_eq("sw_dbg", dbg_data, 32'hDEADBEEF);
        xact(0, 3'b010, 32'h10, 0, rd, er, lat);
        check_eq("lw_rdata", rd, 32'hDEADBEEF);
        check_eq("lw_err", er, 0);

        // Byte store and sub-word loads
        xact(1, 3'b000, 32'h13, 32'h00000080, rd, er, lat);
        check_eq("sb_err", er, 0);
        xact(0, 3'b000, 32'h13, 0, rd, er, lat);
        check_eq("lb_rdata", rd, 32'hFFFFFF80);
        xact(0, 3'b100, 32'h13, 0, rd, er, lat);
        check_eq("lbu_rdata", rd, 32'h00000080);
        xact(0, 3'b010, 32'h10, 0, rd, er, lat);
        check_eq("lw_after_sb", rd, 32'h80ADBEEF);
        xact(0, 3'b101, 32'h12, 0, rd, er, lat);
        check_eq("lhu_hi", rd, 32'h000080AD);
        xact(0, 3'b001, 32'h12, 0, rd, er, lat);
        check_eq("lh_hi", rd, 32'hFFFF80AD);

        // Misaligned accesses
        xact(0, 3'b001, 32'h11, 0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("lh_mis_err", er, 1);
        check_eq("lh_mis_rdata", rd, 0);
`else
        check_eq("lh_mis_err", er, 0);
        check_eq("lh_mis_rdata", rd, 32'hFFFFBEEF);
`endif
        xact(0, 3'b010, 32'h12, 0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("lw_mis_err", er, 1);
        check_eq("lw_mis_rdata", rd, 0);
`else
        check_eq("lw_mis_err", er, 0);
        check_eq("lw_mis_rdata", rd, 32'h80ADBEEF);
`endif

        // Illegal funct3
        xact(0, 3'b011, 32'h10, 0, rd, er, lat);
        check_eq("ld_f3_3_err", er, 1);
        check_eq("ld_f3_3_rdata", rd, 0);
        xact(1, 3'b011, 32'h10, 32'h12345678, rd, er, lat);
        check_eq("st_f3_3_err", er, 1);
        check_eq("st_f3_3_mem", dbg_data, 32'h80ADBEEF);

        // Address wraps modulo MEM_SIZE*4
        xact(0, 3'b010, 32'h2010, 0, rd, er, lat);
        check_eq("lw_wrap", rd, 32'h80ADBEEF);

        // Response held while rsp_ready_i is low
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b010;
        bus.req_addr_i   = 32'h10;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("hold_reach", bus.rsp_valid_o, 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", bus.rsp_valid_o, 1);
            check_eq("hold_rdata", bus.rsp_rdata_o, 32'h80ADBEEF);
            check_eq("hold_req_ready", bus.req_ready_o, 0);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check_eq("hold_done_valid", bus.rsp_valid_o, 0);
        check_eq("hold_done_ready", bus.req_ready_o, 1);

        // Same-cycle store and debug read returns old word
        dbg_addr = 11'd8;
        xact(1, 3'b010, 32'h20, 32'h11112222, rd, er, lat);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b1;
        bus.req_funct3_i = 3'b010;
        bus.req_addr_i   = 32'h20;
        bus.req_wdata_i  = 32'h33334444;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check_eq("dbg_old_word", dbg_data, 32'h11112222);
        @(negedge clk);
        check_eq("dbg_new_word", dbg_data, 32'h33334444);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;

        // Reset during WAIT discards the store
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_wdata_i = 32'h55556666;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check_eq("rstw_busy_before", busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("rstw_valid", bus.rsp_valid_o, 0);
        check_eq("rstw_busy", busy, 0);
        check_eq("rstw_mem", dbg_data, 32'h33334444);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("rstw_valid_after", bus.rsp_valid_o, 0);
        check_eq("rstw_ready_after", bus.req_ready_o, 1);
        check_eq("rstw_mem_after", dbg_data, 32'h33334444);

        // Halfword store into upper lanes
        xact(1, 3'b001, 32'h22, 32'h0000CAFE, rd, er, lat);
        xact(0, 3'b010, 32'h20, 0, rd, er, lat);
        check_eq("sh_merge", rd, 32'hCAFE4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have parameter MEM_SIZE, default 2048, meaning data memory depth in XLEN-bit words (power of 2).
REQ-003 SHALL have parameter LATENCY, default 1, range 0..7, meaning wait cycles between accept and response.
REQ-004 SHALL have one clock and a synchronous active-low reset: clk_i  in  1  clock; rstn_i  in  1  synchronous active-low reset.
REQ-005 SHALL have the request ports:
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with valid
- req_we_i  in  1  1=store, 0=load
- req_funct3_i  in  3  RV32I load/store funct3
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data
REQ-006 SHALL have the response ports:
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  XLEN  load result
- rsp_err_o  out  1  request faulted
REQ-007 SHALL have the status and debug ports:
- busy_o  out  1  FSM not IDLE
- dbg_addr_i  in  $clog2(MEM_SIZE)  debug word index
- dbg_data_o  out  XLEN  combinational read of that word

Function
REQ-008 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready_o = (state==IDLE) && rstn_i.
REQ-009 SHALL capture the request on req_valid_i && req_ready_o, load the wait counter with LATENCY, and enter WAIT.
REQ-010 SHALL, in WAIT, decrement the counter and perform the access when it reaches 0, then enter RESP; LATENCY=0 goes to RESP one cycle after accept.
REQ-011 SHALL assert rsp_valid_o exactly from cycle T+1+LATENCY, where T is the accept cycle, and hold it with stable rdata/err until rsp_ready_i is high.
REQ-012 SHALL treat rsp_ready_i high in RESP as completion, returning to IDLE; no new accept occurs in that same cycle.
REQ-013 SHALL form the word index from addr[$clog2(MEM_SIZE)+1:2]; higher address bits are ignored (wrap modulo MEM_SIZE*4 bytes).
REQ-014 SHALL, for loads, select the byte/half lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word.
REQ-015 SHALL, for stores, write only the addressed lanes (SB 1 byte, SH 2 bytes, SW 4 bytes) and return rsp_rdata_o=0.
REQ-016 SHALL treat load funct3 3/6/7 and store funct3 >=3 as illegal: rsp_err_o=1, rsp_rdata_o=0, no memory write.
REQ-017 SHALL, when a store and a dbg read target the same word in the same cycle, return the old data on dbg_data_o.

Reset
REQ-018 SHALL, with rstn_i low at a clock edge, go to IDLE, clear the counter and drive rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0, req_ready_o=0.
REQ-019 SHALL discard a pending (unperformed) store on reset mid-operation and SHALL NOT clear memory contents.

Configuration
REQ-020 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, flag misaligned accesses (half with addr[0]=1; word with addr[1:0]!=0) as rsp_err_o=1, rsp_rdata_o=0, no write.
REQ-021 SHALL, without LSU_MISALIGN_TRAP_EN, clear the offending low address bits to the access size and complete normally with rsp_err_o=0.

Structure
REQ-022 SHALL take XLEN and the F3_LB..F3_SW constants from riscv_pkg, and SHALL add typedef lsu_state_e {IDLE, WAIT, RESP} to riscv_pkg.
REQ-023 SHALL place lane extraction, sign extension and byte-enable generation in one combinational sub-module, lsu_align.

Verification
REQ-024 SHALL cover these directed scenarios:
- SW 0xDEADBEEF @0x10, LATENCY=1 -> rsp_valid 2 cycles after accept; LW @0x10 -> 0xDEADBEEF, err=0.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- LH @0x11 with macro -> err=1, rdata=0; without macro -> reads the half at 0x10 (0xBEEF sign-extended = 0xFFFFBEEF).
- funct3=3 load -> err=1; store funct3=3 -> err=1 and the memory word is unchanged.
- rsp_ready_i held low 5 cycles -> rsp_valid/rdata stable and req_ready_o=0 throughout.
- rstn_i low during WAIT of SW @0x20 -> IDLE next cycle, word 0x20 unchanged, rsp_valid_o=0.
